// File: rtl/job_control_if.sv
// ----------------------------------------------------------------------------
// job_control_if
//   PSL job bus between the PSL (master) and the job_control front end (slave).
//
//   Job-in group (PSL -> AFU):
//     job_valid    one-cycle command strobe
//     job_command  8-bit command code (0x80 RESET, 0x90 START, 0x42 TIMEBASE,
//                  0x45 LLCMD)
//     job_cpar     odd parity over job_command
//     job_address  64-bit WED pointer accompanying START
//     job_apar     odd parity over job_address
//   Job-out group (AFU -> PSL):
//     job_running  high while a started job is in progress
//     job_done     one-cycle completion pulse
//     job_cack     LLCMD acknowledge (LLCMD is not supported, so it stays 0)
//     job_error    completion status; non-zero only while job_done is high
//     job_yield    always 0
//
//   Handshake: the job bus has no ready. A command is presented for exactly
//   one cycle with job_valid=1 and is consumed in that cycle; the AFU answers
//   via the job-out group on later cycles.
// ----------------------------------------------------------------------------
interface job_control_if #(
    parameter int ERROR_W = 64
) ();
    logic               job_valid;
    logic [7:0]         job_command;
    logic               job_cpar;
    logic [63:0]        job_address;
    logic               job_apar;
    logic               job_running;
    logic               job_done;
    logic               job_cack;
    logic [ERROR_W-1:0] job_error;
    logic               job_yield;

    modport master (
        output job_valid, job_command, job_cpar, job_address, job_apar,
        input  job_running, job_done, job_cack, job_error, job_yield
    );

    modport slave (
        input  job_valid, job_command, job_cpar, job_address, job_apar,
        output job_running, job_done, job_cack, job_error, job_yield
    );
endinterface

// File: rtl/job_control.sv
// ----------------------------------------------------------------------------
// job_control
//   Job-interface front end for the PSL AFU. Decodes PSL job commands, drives
//   the job-out running/done handshake, latches the WED pointer and gives the
//   AFU core a one-cycle start pulse. Completion status from the core is
//   returned to the PSL as a one-cycle job_done with job_error.
//
//   Parameters:
//     RESET_CYCLES  cycles core_reset is held after a RESET command (>=1)
//     ERROR_W       width of job_error (must match the interface)
//
//   Ports:
//     clock        single AFU clock, posedge
//     reset_n      synchronous active-low reset
//     job          job_control_if.slave - PSL job bus
//     core_done    core finished its job (level or pulse)
//     core_error   core finished with error, sampled with core_done
//     core_reset   reset to the AFU core
//     core_start   one-cycle start pulse to the AFU core
//     wed          WED pointer latched on START
//     dbg_state    current FSM state (IDLE=0, RESETTING=1, RUNNING=2, FINISH=3)
//
//   Optional feature: define JOB_PARITY_CHECK_EN to check odd parity on every
//   job_valid. A bad command parity discards the command, a bad address
//   parity discards a START; either way a done pulse with job_error=2
//   follows and a running job is aborted.
//
//   Timing:
//     RESET accepted at edge N -> core_reset=1 for RESET_CYCLES cycles, then
//       job_done for one cycle with core_reset already 0.
//     START accepted at edge N -> core_start and job_running high from the
//       next cycle.
//     core_done seen in RUNNING at edge N -> job_running=0 and job_done=1 in
//       the next cycle (the FINISH state).
// ----------------------------------------------------------------------------
module job_control #(
    parameter int RESET_CYCLES = 4,
    parameter int ERROR_W      = 64
) (
    input  logic                 clock,
    input  logic                 reset_n,
    job_control_if.slave         job,
    input  logic                 core_done,
    input  logic                 core_error,
    output logic                 core_reset,
    output logic                 core_start,
    output logic [63:0]          wed,
    output logic [1:0]           dbg_state
);

    localparam logic [7:0] CMD_RESET = 8'h80;
    localparam logic [7:0] CMD_START = 8'h90;

    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RESETTING = 2'd1,
        S_RUNNING   = 2'd2,
        S_FINISH    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               core_reset_q, core_reset_d;
    logic               core_start_q, core_start_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic [ERROR_W-1:0] error_q, error_d;
    logic [63:0]        wed_q, wed_d;

    logic is_reset;
    logic is_start;
    logic par_err;
    logic accept_reset;
    logic accept_start;

    assign is_reset = job.job_valid && (job.job_command == CMD_RESET);
    assign is_start = job.job_valid && (job.job_command == CMD_START);

`ifdef JOB_PARITY_CHECK_EN
    logic cpar_ok;
    logic apar_ok;

    // Odd parity: data bits plus parity bit contain an odd number of ones.
    assign cpar_ok = ^{job.job_command, job.job_cpar};
    assign apar_ok = ^{job.job_address, job.job_apar};
    assign par_err = job.job_valid && (!cpar_ok || (is_start && !apar_ok));
`else
    assign par_err = 1'b0;
`endif

    assign accept_reset = is_reset && !par_err;
    assign accept_start = is_start && !par_err;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        core_reset_d = core_reset_q;
        core_start_d = 1'b0;
        running_d    = running_q;
        done_d       = 1'b0;
        error_d      = '0;
        wed_d        = wed_q;

        if (accept_reset) begin
            // RESET wins in every state and aborts any job silently.
            state_d      = S_RESETTING;
            cnt_d        = '0;
            core_reset_d = 1'b1;
            running_d    = 1'b0;
        end else if (par_err) begin
            // Report the parity error through a done pulse; any job in
            // flight or reset countdown is abandoned. core_reset keeps its
            // value so the core is never released by a corrupted command.
            state_d    = S_FINISH;
            cnt_d      = '0;
            running_d  = 1'b0;
            done_d     = 1'b1;
            error_d[1] = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept_start) begin
                        state_d      = S_RUNNING;
                        wed_d        = job.job_address;
                        core_start_d = 1'b1;
                        running_d    = 1'b1;
                    end
                end
                S_RESETTING: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d      = S_FINISH;
                        cnt_d        = '0;
                        core_reset_d = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RUNNING: begin
                    if (core_done) begin
                        state_d    = S_FINISH;
                        running_d  = 1'b0;
                        done_d     = 1'b1;
                        error_d[0] = core_error;
                    end
                end
                S_FINISH: begin
                    // job_done is high during this single cycle.
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
            core_start_q <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= '0;
            wed_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_reset_q <= core_reset_d;
            core_start_q <= core_start_d;
            running_q    <= running_d;
            done_q       <= done_d;
            error_q      <= error_d;
            wed_q        <= wed_d;
        end
    end

    assign core_reset      = core_reset_q;
    assign core_start      = core_start_q;
    assign wed             = wed_q;
    assign dbg_state       = state_q;

    assign job.job_running = running_q;
    assign job.job_done    = done_q;
    assign job.job_error   = error_q;
    assign job.job_cack    = 1'b0;
    assign job.job_yield   = 1'b0;

endmodule

// File: tb/tb_job_control.sv
// ----------------------------------------------------------------------------
// tb_job_control
//   Bench for job_control: directed scenarios followed by random job traffic,
//   every cycle compared against a behavioural model of the job protocol.
// ----------------------------------------------------------------------------
module tb_job_control;

  localparam int RESET_CYCLES = 4;
  localparam int ERROR_W      = 64;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT
  job_control_if #(.ERROR_W(ERROR_W)) jif ();
  logic        core_done;
  logic        core_error;
  logic        core_reset;
  logic        core_start;
  logic [63:0] wed;
  logic [1:0]  dbg_state;

  job_control #(.RESET_CYCLES(RESET_CYCLES), .ERROR_W(ERROR_W)) dut (
    .clock      (clk),
    .reset_n    (reset_n),
    .job        (jif.slave),
    .core_done  (core_done),
    .core_error (core_error),
    .core_reset (core_reset),
    .core_start (core_start),
    .wed        (wed),
    .dbg_state  (dbg_state)
  );

  // scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // reference model: protocol-level bookkeeping
  bit          m_core_reset;
  int          m_reset_left;   // core_reset cycles still to come
  bit          m_running;
  bit          m_start;
  bit          m_done;
  logic [63:0] m_err;
  logic [63:0] m_wed;

  task automatic model_reset();
    m_core_reset = 1'b1;
    m_reset_left = 0;
    m_running    = 1'b0;
    m_start      = 1'b0;
    m_done       = 1'b0;
    m_err        = '0;
    m_wed        = '0;
  endtask

  // Advance the model by one clock using the inputs driven this cycle.
  task automatic model_step();
    bit          nx_start = 1'b0;
    bit          nx_done  = 1'b0;
    logic [63:0] nx_err   = '0;
    bit          perr     = 1'b0;
    bit          v        = jif.job_valid;
    logic [7:0]  cmd      = jif.job_command;
`ifdef JOB_PARITY_CHECK_EN
    if (v) begin
      if (($countones(cmd) + int'(jif.job_cpar)) % 2 == 0) perr = 1'b1;
      if (cmd == 8'h90 && ($countones(jif.job_address) + int'(jif.job_apar)) % 2 == 0) perr = 1'b1;
    end
`endif
    if (v && cmd == 8'h80 && !perr) begin
      m_reset_left = RESET_CYCLES;
      m_core_reset = 1'b1;
      m_running    = 1'b0;
    end else if (perr) begin
      m_reset_left = 0;
      m_running    = 1'b0;
      nx_done      = 1'b1;
      nx_err       = 64'd2;
    end else if (m_reset_left > 0) begin
      m_reset_left--;
      if (m_reset_left == 0) begin
        m_core_reset = 1'b0;
        nx_done      = 1'b1;
      end
    end else if (m_running) begin
      if (core_done) begin
        m_running = 1'b0;
        nx_done   = 1'b1;
        nx_err    = {63'd0, core_error};
      end
    end else if (!m_done && v && cmd == 8'h90) begin
      m_wed     = jif.job_address;
      nx_start  = 1'b1;
      m_running = 1'b1;
    end
    m_start = nx_start;
    m_done  = nx_done;
    m_err   = nx_err;
  endtask

  task automatic check_all();
    check_eq("core_reset",  {63'd0, core_reset},      {63'd0, m_core_reset});
    check_eq("core_start",  {63'd0, core_start},      {63'd0, m_start});
    check_eq("wed",         wed,                      m_wed);
    check_eq("job_running", {63'd0, jif.job_running}, {63'd0, m_running});
    check_eq("job_done",    {63'd0, jif.job_done},    {63'd0, m_done});
    check_eq("job_error",   jif.job_error,            m_err);
    check_eq("job_cack",    {63'd0, jif.job_cack},    64'd0);
    check_eq("job_yield",   {63'd0, jif.job_yield},   64'd0);
    check_eq("done_xor_running",
             {63'd0, jif.job_done & jif.job_running}, 64'd0);
  endtask

  // driver: one clock cycle with the given inputs; outputs checked on negedge
  task automatic cycle(input bit v, input logic [7:0] cmd, input logic [63:0] addr,
                       input bit cd, input bit ce, input bit bad_c, input bit bad_a);
    jif.job_valid   = v;
    jif.job_command = cmd;
    jif.job_address = addr;
    jif.job_cpar    = (~^cmd) ^ bad_c;
    jif.job_apar    = (~^addr) ^ bad_a;
    core_done       = cd;
    core_error      = ce;
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] cmd, input logic [63:0] addr);
    cycle(1'b1, cmd, addr, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    jif.job_valid   = 1'b0;
    jif.job_command = '0;
    jif.job_cpar    = 1'b1;
    jif.job_address = '0;
    jif.job_apar    = 1'b1;
    core_done       = 1'b0;
    core_error      = 1'b0;
    model_reset();

    // power-on reset held for 3 cycles
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // RESET sequence
    send(8'h80, 64'd0);
    idle(7);

    // START, then clean completion
    send(8'h90, 64'h0000_1000_0000_0040);
    idle(3);
    cycle(1'b0, 8'h00, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // START, ignored second START, error completion
    send(8'h90, 64'h0000_2000_0000_0080);
    idle(2);
    send(8'h90, 64'hdead_beef_0000_0100);
    idle(1);
    cycle(1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);

    // core_done in IDLE is ignored; TIMEBASE/LLCMD ignored
    cycle(1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h42, 64'd5);
    send(8'h45, 64'd6);
    idle(2);

    // core_done in the same cycle as START accept is not seen
    cycle(1'b1, 8'h90, 64'h0000_3000_0000_00c0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // RESET aborts a running job
    send(8'h80, 64'd0);
    idle(7);

`ifdef JOB_PARITY_CHECK_EN
    // START with bad address parity
    cycle(1'b1, 8'h90, 64'h0000_4000_0000_0100, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // RESET with bad command parity is discarded
    cycle(1'b1, 8'h80, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit          v;
      bit          bc;
      bit          ba;
      logic [7:0]  cmd;
      logic [63:0] addr;
      int          r;
      v = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 19);
      if (r == 0)       cmd = 8'h80;
      else if (r <= 8)  cmd = 8'h90;
      else if (r <= 11) cmd = 8'h42;
      else if (r <= 13) cmd = 8'h45;
      else              cmd = 8'($urandom_range(0, 255));
      addr = {$urandom, $urandom};
      bc = 1'b0;
      ba = 1'b0;
`ifdef JOB_PARITY_CHECK_EN
      bc = ($urandom_range(0, 15) == 0);
      ba = ($urandom_range(0, 15) == 0);
`endif
      cycle(v, cmd, addr, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, bc, ba);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
